// File: rtl/tpu_array_sched_if.sv
// Host command, array control and drain handshake bundle for tpu_array_sched.
// master = scheduler side, slave = host/array/buffer side.
interface tpu_array_sched_if #(
  parameter int DIM = 8
);
  localparam int CNT_W = $clog2(3 * DIM);
  localparam int ROW_W = $clog2(DIM);

  logic             start;
  logic             abort;
  logic             stall;
  logic             busy;
  logic             done;
  logic             c_wren;
  logic [ROW_W-1:0] c_row;
  logic             mac_en;
  logic [CNT_W-1:0] step;
  logic [DIM-1:0]   lane_vld;
  logic             drain_vld;
  logic             drain_rdy;
  logic [31:0]      perf_cycles;
  logic [31:0]      perf_stalls;

  modport master (
    input  start, abort, stall, drain_rdy,
    output busy, done, c_wren, c_row, mac_en, step, lane_vld, drain_vld,
           perf_cycles, perf_stalls
  );

  modport slave (
    output start, abort, stall, drain_rdy,
    input  busy, done, c_wren, c_row, mac_en, step, lane_vld, drain_vld,
           perf_cycles, perf_stalls
  );
endinterface

// File: rtl/tpu_array_sched.sv
// Phase sequencer for a DIM x DIM systolic array: preload, skewed feed, drain, done.
// Optional busy/stall performance counters are built when TPU_SCHED_PERF_EN is defined.
module tpu_array_sched #(
  parameter int DIM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tpu_array_sched_if.master bus
);
  localparam int CNT_W = $clog2(3 * DIM);
  localparam int ROW_W = $clog2(DIM);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(3 * DIM - 3);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             busy_q, done_q, wren_q, feed_q, drain_q;
  logic [DIM-1:0]   lane_vld;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d = state_q;
    row_d   = row_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PRELOAD;
          row_d   = '0;
          step_d  = '0;
        end
      end
      S_PRELOAD: begin
        if (row_q == ROW_LAST) begin
          state_d = S_FEED;
          row_d   = '0;
          step_d  = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_FEED: begin
        if (!bus.stall) begin
          if (step_q == STEP_LAST) begin
            state_d = S_DRAIN;
            row_d   = '0;
            step_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // drain_vld is constantly high here, so the handshake reduces to drain_rdy.
        if (bus.drain_rdy) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort is ignored in IDLE so a simultaneous start still launches the job.
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      row_d   = '0;
      step_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      feed_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      step_q  <= step_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      wren_q  <= (state_d == S_PRELOAD);
      feed_q  <= (state_d == S_FEED);
      drain_q <= (state_d == S_DRAIN);
    end
  end

  // Diagonal wavefront: lane i is live for DIM steps starting at step i.
  always_comb begin
    lane_vld = '0;
    for (int i = 0; i < DIM; i++) begin
      lane_vld[i] = feed_q && (int'(step_q) >= i) && (int'(step_q) - i < DIM);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.c_wren    = wren_q;
  assign bus.c_row     = row_q;
  assign bus.mac_en    = feed_q & ~bus.stall;
  assign bus.step      = step_q;
  assign bus.lane_vld  = lane_vld;
  assign bus.drain_vld = drain_q;

`ifdef TPU_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy_q && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 1'b1;
      if (feed_q && bus.stall && perf_stalls_q != '1) perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_stalls = '0;
`endif
endmodule

// File: tb/tb_tpu_array_sched.sv
// Bench for tpu_array_sched at DIM=4: progress-counter reference model checked every cycle,
// plus directed jobs (basic, stall, backpressure, abort, reset) with literal expectations.
module tb_tpu_array_sched;
  localparam int DIM    = 4;
  localparam int FEED_N = 3 * DIM - 2;
  localparam int BUDGET = 200;

  logic clk;
  logic rst_n;

  tpu_array_sched_if #(.DIM(DIM)) bus ();

  tpu_array_sched #(.DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Job progress as the spec describes it: rows preloaded, enabled feed steps, rows drained.
  bit m_active = 1'b0;
  int m_pre, m_fed, m_drained;
  int m_pc = 0;
  int m_ps = 0;

  task automatic compare_outputs();
    bit ph_pre, ph_feed, ph_drain, ph_done;
    logic [DIM-1:0] exp_lane;
    int exp_pc, exp_ps;
    ph_pre   = m_active && (m_pre < DIM);
    ph_feed  = m_active && !ph_pre && (m_fed < FEED_N);
    ph_drain = m_active && !ph_pre && !ph_feed && (m_drained < DIM);
    ph_done  = m_active && !ph_pre && !ph_feed && !ph_drain;
    exp_lane = '0;
    for (int i = 0; i < DIM; i++) exp_lane[i] = ph_feed && (m_fed >= i) && (m_fed < i + DIM);

    check("busy",      32'(bus.busy),      32'(m_active));
    check("done",      32'(bus.done),      32'(ph_done));
    check("c_wren",    32'(bus.c_wren),    32'(ph_pre));
    check("mac_en",    32'(bus.mac_en),    32'(ph_feed && !bus.stall));
    check("drain_vld", 32'(bus.drain_vld), 32'(ph_drain));
    if (ph_pre)   check("c_row_preload", 32'(bus.c_row), 32'(m_pre));
    if (ph_drain) check("c_row_drain",   32'(bus.c_row), 32'(m_drained));
    if (ph_feed) begin
      check("step",     32'(bus.step),     32'(m_fed));
      check("lane_vld", 32'(bus.lane_vld), 32'(exp_lane));
    end
    if (!m_active) begin
      check("idle_c_row",    32'(bus.c_row),    32'd0);
      check("idle_step",     32'(bus.step),     32'd0);
      check("idle_lane_vld", 32'(bus.lane_vld), 32'd0);
    end
`ifdef TPU_SCHED_PERF_EN
    exp_pc = m_pc;
    exp_ps = m_ps;
`else
    exp_pc = 0;
    exp_ps = 0;
`endif
    check("perf_cycles", bus.perf_cycles, 32'(exp_pc));
    check("perf_stalls", bus.perf_stalls, 32'(exp_ps));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_active = 1'b0;
      m_pc = 0;
      m_ps = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active  = 1'b1;
        m_pre     = 0;
        m_fed     = 0;
        m_drained = 0;
        m_pc      = 0;
        m_ps      = 0;
      end
    end else begin
      m_pc++;
      if (m_pre >= DIM && m_fed < FEED_N && bus.stall) m_ps++;
      if (bus.abort)                   m_active = 1'b0;
      else if (m_pre < DIM)            m_pre++;
      else if (m_fed < FEED_N)         begin if (!bus.stall) m_fed++; end
      else if (m_drained < DIM)        begin if (bus.drain_rdy) m_drained++; end
      else                             m_active = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      model_edge();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [DIM-1:0] lane_log [16];

  task automatic run_job(input int stall_step, input int stall_len, input int bp_row,
                         input int bp_len, input bit poke_start, input bit with_abort,
                         output int bc, output int dc, output int mc);
    int t, stalled, held;
    bus.start = 1'b1;
    bus.abort = with_abort;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bc = 0; dc = 0; mc = 0; t = 0; stalled = 0; held = 0;
    while (bus.busy && t < BUDGET) begin
      t++;
      bc++;
      if (bus.done) begin
        dc = t;
        bus.start = poke_start;
      end
      bus.stall = 1'b0;
      if (bus.busy && !bus.c_wren && !bus.drain_vld && !bus.done &&
          int'(bus.step) == stall_step && stalled < stall_len) begin
        bus.stall = 1'b1;
        stalled++;
      end
      bus.drain_rdy = 1'b1;
      if (bus.drain_vld && int'(bus.c_row) == bp_row && held < bp_len) begin
        bus.drain_rdy = 1'b0;
        held++;
      end
      #1;
      if (bus.stall) begin
        check("stall_step_hold", 32'(bus.step), 32'(stall_step));
        check("stall_mac_en",    32'(bus.mac_en), 32'd0);
      end
      if (bus.mac_en) begin
        mc++;
        lane_log[bus.step] = bus.lane_vld;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.stall     = 1'b0;
    bus.drain_rdy = 1'b1;
    check("job_returns_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int bc, dc, mc, n, dp, bp;
    logic [DIM-1:0] exp_lanes [10];
    exp_lanes = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                  4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    bus.drain_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_step",     32'(bus.step),     32'd0);
    check("reset_lane_vld", 32'(bus.lane_vld), 32'd0);

    // Basic job; start pulsed during DONE must be ignored.
    run_job(-1, 0, -1, 0, 1'b1, 1'b0, bc, dc, mc);
    check("basic_busy_cycles", 32'(bc), 32'd19);
    check("basic_done_cycle",  32'(dc), 32'd19);
    check("basic_mac_cycles",  32'(mc), 32'd10);
    for (int k = 0; k < 10; k++) check("skew_lane_seq", 32'(lane_log[k]), 32'(exp_lanes[k]));
    @(posedge clk); #1;
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);

    // Stall for 3 cycles at step 5.
    run_job(5, 3, -1, 0, 1'b0, 1'b0, bc, dc, mc);
    check("stall_busy_cycles", 32'(bc), 32'd22);
    check("stall_done_cycle",  32'(dc), 32'd22);
    check("stall_mac_cycles",  32'(mc), 32'd10);
`ifdef TPU_SCHED_PERF_EN
    check("perf_cycles_stall_job", bus.perf_cycles, 32'd22);
    check("perf_stalls_stall_job", bus.perf_stalls, 32'd3);
`endif

    // Drain backpressure: row 2 refused for 2 cycles.
    run_job(-1, 0, 2, 2, 1'b0, 1'b0, bc, dc, mc);
    check("bp_busy_cycles", 32'(bc), 32'd21);
    check("bp_done_cycle",  32'(dc), 32'd21);

    // Abort at step 6.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!(bus.mac_en && int'(bus.step) == 6) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach_step6", 32'(n < 100), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_mac_en", 32'(bus.mac_en), 32'd0);
    dp = 0; bp = 0;
    repeat (25) begin
      if (bus.done) dp++;
      if (bus.busy) bp++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(dp), 32'd0);
    check("abort_stays_idle", 32'(bp), 32'd0);

    // Restart with abort asserted on the same edge: start wins, clean 19-cycle job.
    run_job(-1, 0, -1, 0, 1'b0, 1'b1, bc, dc, mc);
    check("restart_busy_cycles", 32'(bc), 32'd19);
    check("restart_done_cycle",  32'(dc), 32'd19);

    // Reset mid-DRAIN with start held alongside.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!(bus.drain_vld && int'(bus.c_row) == 1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_reach_drain", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b0;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_drain_vld", 32'(bus.drain_vld), 32'd0);
    check("rst_c_row",     32'(bus.c_row),     32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_perf",      bus.perf_cycles,    32'd0);
    bp = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.busy) bp++;
    end
    check("rst_start_ignored", 32'(bp), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tpu_array_sched.md
Name: tpu_array_sched

Overview:
- Sequencing controller for a DIM x DIM systolic array of tpumac cells.
- Steps the array through four phases per job:
  - accumulator preload (row-by-row WrEn);
  - skewed A/B streaming with the array enable;
  - accumulator drain through a valid/ready port;
  - a one-cycle done pulse.
- Sits between the host command interface and the array plus its A/B/C operand buffers. It is control only: it generates no datapath values.

Parameters:
- DIM, 8: array dimension (rows = cols = DIM); legal range 2..64.
- CNT_W, $clog2(3*DIM): localparam; width of the step counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- start  in  1  job request; accepted only in IDLE.
- abort  in  1  return to IDLE from any state on next edge; no done pulse.
- stall  in  1  operand buffers not ready; freezes the FEED phase.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- c_wren  out  1  accumulator load strobe (array WrEn) for row c_row.
- c_row  out  $clog2(DIM)  row index for preload and drain.
- mac_en  out  1  array en.
- step  out  CNT_W  feed step k, 0..3*DIM-3.
- lane_vld  out  DIM  bit i = operand lane i (A row i / B col i) carries real data this step; otherwise the buffer drives 0.
- drain_vld  out  1  C row c_row is presented to the drain consumer.
- drain_rdy  in  1  consumer accepts the row.
- perf_cycles  out  32  see Optional Feature.
- perf_stalls  out  32  see Optional Feature.

Behaviour:
- States: IDLE, PRELOAD, FEED, DRAIN, DONE.

Reset:
- Synchronous and active-low. Reset has priority over abort and start.
- On reset: state=IDLE and all counters=0.
- Outputs at reset: busy=0, done=0, c_wren=0, mac_en=0, drain_vld=0, c_row=0, step=0, lane_vld=0.
- Reset mid-job discards the job immediately; no done pulse.

IDLE:
- start=1 at an edge -> PRELOAD, with c_row=0.
- start while busy is ignored; it is not queued.

PRELOAD (DIM cycles):
- c_wren=1 and mac_en=0.
- c_row increments 0..DIM-1 each cycle.
- After row DIM-1 -> FEED, with step=0.

FEED:
- Not stalled: mac_en=1 and step increments.
- stall=1: mac_en=0, and step and lane_vld hold.
- lane_vld[i] = (step >= i) && (step - i < DIM), computed combinationally from step.
- After step 3*DIM-3 is consumed with stall=0 -> DRAIN, with c_row=0.
- The FEED phase contains exactly 3*DIM-2 enabled cycles.

DRAIN:
- drain_vld=1, mac_en=0, c_wren=0.
- c_row advances only on (drain_vld && drain_rdy).
- Once row DIM-1 is accepted -> DONE.
- c_row must stay stable while drain_vld=1 and drain_rdy=0.

DONE (1 cycle):
- done=1 and busy=1, then -> IDLE.
- start during DONE is ignored.

Abort:
- abort=1 in any non-IDLE state -> IDLE on the next edge, with outputs at their reset values.
- abort in IDLE has no effect.
- If abort and start arrive on the same edge in IDLE, start wins.

Latency (no stall, drain_rdy=1):
- busy is high for DIM + (3*DIM-2) + DIM + 1 cycles.
- For DIM=4 that is 19 cycles.

Mutual exclusion: c_wren, mac_en and drain_vld are mutually exclusive in every cycle.

Optional Feature:
- Macro: TPU_SCHED_PERF_EN.
- Defined:
  - perf_cycles counts every cycle with busy=1 for the current job.
  - perf_stalls counts FEED cycles with stall=1.
  - Both counters clear when start is accepted, then hold after DONE until the next start.
  - Both saturate at 32'hFFFF_FFFF.
  - Reset clears both.
- Undefined: both ports are still present and tied to 0; no counter logic is instantiated.

Test Plan (DIM=4):
- Basic job: pulse start, drain_rdy=1, no stall:
  - c_wren high on cycles 1-4 with c_row 0,1,2,3;
  - mac_en high for 10 cycles, step 0..9;
  - drain_vld for 4 cycles;
  - done on cycle 19, busy low on cycle 20.
- Skew check: during FEED, lane_vld follows this sequence across steps 0..9: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0000, 0000.
- Stall: hold stall=1 for 3 cycles at step=5:
  - mac_en=0 and step stays at 5 for those 3 cycles;
  - total busy = 22 cycles;
  - with PERF_EN: perf_stalls=3 and perf_cycles=22.
- Drain backpressure: drain_rdy low for 2 cycles on row 2:
  - c_row holds at 2 with drain_vld=1;
  - done is delayed by 2 cycles.
- Abort at step=6: next cycle state=IDLE, busy=0, mac_en=0; done never pulses. A new start then runs a clean 19-cycle job.
- Reset mid-DRAIN with rst_n=0 for 1 cycle: all outputs at reset values on the next cycle. start asserted together with rst_n=0 is ignored.
